// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants and state encoding for the fetch stage
package fetch_stage_pkg;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC_DEF   = 32'd4;
  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_e;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: hazard/redirect inputs, imem port and IF/ID outputs of the fetch stage
interface fetch_stage_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        align_err;
  logic [15:0] fetch_count;
  logic [7:0]  stall_count;
  modport master (
    output stall, branch_taken, branch_target, inst_data,
    input  inst_addr, if_id_instr, if_id_pc4, if_id_valid, align_err, fetch_count, stall_count
  );
  modport slave (
    input  stall, branch_taken, branch_target, inst_data,
    output inst_addr, if_id_instr, if_id_pc4, if_id_valid, align_err, fetch_count, stall_count
  );
endinterface

// File: rtl/fetch_stage_pc_unit.sv
// pc_unit: program counter with reset, redirect load, hold and sequential increment
module pc_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] load_value,
  output logic [31:0] pc
);
  logic [31:0] pc_q, pc_d;
  always_comb pc_d = load ? load_value : hold ? pc_q : pc_q + PC_INC;
  always_ff @(posedge clk)
    if (Reset) pc_q <= PC_RESET;
    else pc_q <= pc_d;
  assign pc = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: BOOT/RUN/HOLD fetch FSM driving the PC, the IF/ID register and fetch/stall counters
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter logic [31:0] PC_INC   = PC_INC_DEF
) (
  input logic          clk,
  input logic          Reset,
  fetch_stage_if.slave bus
);
  state_e      state_q, state_d;
  logic [31:0] pc, if_id_instr_q, if_id_instr_d, if_id_pc4_q, if_id_pc4_d;
  logic        if_id_valid_q, if_id_valid_d, align_err_q, align_err_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [7:0]  stall_count_q, stall_count_d;
  logic        br, adv, stl;
  pc_unit #(.PC_RESET(PC_RESET), .PC_INC(PC_INC)) u_pc (
    .clk        (clk),
    .Reset      (Reset),
    .hold       (!br && (bus.stall || state_q == BOOT)),
    .load       (br),
    .load_value ({bus.branch_target[31:2], 2'b00}),
    .pc         (pc)
  );
  // redirect outranks stall; BOOT neither fetches nor counts stalls
  always_comb begin
    br            = bus.branch_taken;
    stl           = !br && bus.stall && state_q != BOOT;
    adv           = !br && !bus.stall && state_q != BOOT;
    state_d       = (!br && bus.stall) ? HOLD : RUN;
    if_id_instr_d = br ? NOP_INSTR : adv ? bus.inst_data : if_id_instr_q;
    if_id_pc4_d   = br ? 32'h0 : adv ? pc + PC_INC : if_id_pc4_q;
    if_id_valid_d = br ? 1'b0 : adv ? 1'b1 : if_id_valid_q;
    align_err_d   = align_err_q || (br && bus.branch_target[1:0] != 2'b00);
    fetch_count_d = adv ? fetch_count_q + 16'd1 : fetch_count_q;
    stall_count_d = (stl && stall_count_q != 8'hFF) ? stall_count_q + 8'd1 : stall_count_q;
  end
  always_ff @(posedge clk)
    if (Reset) begin
      state_q       <= BOOT;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc4_q   <= 32'h0;
      if_id_valid_q <= 1'b0;
      align_err_q   <= 1'b0;
      fetch_count_q <= 16'h0;
      stall_count_q <= 8'h0;
    end else begin
      state_q       <= state_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
      align_err_q   <= align_err_d;
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  assign bus.inst_addr   = pc;
  assign bus.if_id_instr = if_id_instr_q;
  assign bus.if_id_pc4   = if_id_pc4_q;
  assign bus.if_id_valid = if_id_valid_q;
  assign bus.align_err   = align_err_q;
  assign bus.fetch_count = fetch_count_q;
  assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
  import fetch_stage_pkg::*;
  logic clk = 1'b0;
  logic Reset;
  int checks = 0;
  int errors = 0;
  fetch_stage_if bus ();
  fetch_stage dut (.clk(clk), .Reset(Reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_state(input string tag, input state_e exp);
    chk(tag, {30'h0, dut.state_q}, {30'h0, exp});
  endtask
  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask
  initial begin
    Reset = 1'b1;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 32'h0;
    bus.inst_data = 32'hE3A0_1001;
    // reset state
    tick();
    chk("rst_addr", bus.inst_addr, 32'h0);
    chk("rst_valid", {31'h0, bus.if_id_valid}, 32'h0);
    chk("rst_instr", bus.if_id_instr, 32'h0);
    chk("rst_fcnt", {16'h0, bus.fetch_count}, 32'h0);
    chk_state("rst_state", BOOT);
    Reset = 1'b0;
    // free run: BOOT holds PC one cycle, then sequential fetches
    tick();
    chk("boot_addr", bus.inst_addr, 32'h0);
    chk("boot_valid", {31'h0, bus.if_id_valid}, 32'h0);
    chk_state("boot_state", RUN);
    tick();
    chk("run1_addr", bus.inst_addr, 32'h4);
    chk("run1_pc4", bus.if_id_pc4, 32'h4);
    tick();
    chk("run2_addr", bus.inst_addr, 32'h8);
    chk("run2_pc4", bus.if_id_pc4, 32'h8);
    tick();
    chk("run3_addr", bus.inst_addr, 32'hC);
    chk("run3_pc4", bus.if_id_pc4, 32'hC);
    chk("run3_fcnt", {16'h0, bus.fetch_count}, 32'd3);
    chk("run3_valid", {31'h0, bus.if_id_valid}, 32'h1);
    chk("run3_instr", bus.if_id_instr, 32'hE3A0_1001);
    // stall at PC=8
    do_reset();
    tick(3);
    chk("pre_stall_addr", bus.inst_addr, 32'h8);
    bus.stall = 1'b1;
    bus.inst_data = 32'hDEAD_BEEF;
    tick(3);
    chk("stall_addr", bus.inst_addr, 32'h8);
    chk("stall_instr", bus.if_id_instr, 32'hE3A0_1001);
    chk("stall_pc4", bus.if_id_pc4, 32'h8);
    chk("stall_scnt", {24'h0, bus.stall_count}, 32'd3);
    chk("stall_fcnt", {16'h0, bus.fetch_count}, 32'd2);
    chk_state("stall_state", HOLD);
    bus.stall = 1'b0;
    tick();
    chk("rel_addr", bus.inst_addr, 32'hC);
    chk("rel_instr", bus.if_id_instr, 32'hDEAD_BEEF);
    chk("rel_pc4", bus.if_id_pc4, 32'hC);
    chk("rel_fcnt", {16'h0, bus.fetch_count}, 32'd3);
    chk_state("rel_state", RUN);
    // branch wins over stall
    bus.stall = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h40;
    tick();
    chk("br_addr", bus.inst_addr, 32'h40);
    chk("br_valid", {31'h0, bus.if_id_valid}, 32'h0);
    chk("br_instr", bus.if_id_instr, 32'h0);
    chk("br_pc4", bus.if_id_pc4, 32'h0);
    chk("br_align", {31'h0, bus.align_err}, 32'h0);
    chk("br_fcnt", {16'h0, bus.fetch_count}, 32'd3);
    chk("br_scnt", {24'h0, bus.stall_count}, 32'd3);
    chk_state("br_state", RUN);
    // misaligned target
    bus.stall = 1'b0;
    bus.branch_target = 32'h43;
    tick();
    chk("mis_addr", bus.inst_addr, 32'h40);
    chk("mis_align", {31'h0, bus.align_err}, 32'h1);
    bus.branch_taken = 1'b0;
    tick(10);
    chk("mis_sticky", {31'h0, bus.align_err}, 32'h1);
    chk("mis_run_addr", bus.inst_addr, 32'h68);
    chk("mis_run_fcnt", {16'h0, bus.fetch_count}, 32'd13);
    // reset coincident with branch and stall
    bus.stall = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h80;
    do_reset();
    chk("rb_addr", bus.inst_addr, 32'h0);
    chk("rb_align", {31'h0, bus.align_err}, 32'h0);
    chk("rb_fcnt", {16'h0, bus.fetch_count}, 32'h0);
    chk("rb_scnt", {24'h0, bus.stall_count}, 32'h0);
    chk_state("rb_state", BOOT);
    // long stall saturates
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    tick();
    bus.stall = 1'b1;
    tick(300);
    chk("sat_scnt", {24'h0, bus.stall_count}, 32'hFF);
    chk("sat_addr", bus.inst_addr, 32'h0);
    chk("sat_fcnt", {16'h0, bus.fetch_count}, 32'h0);
    // 65535 fetches bring fetch_count to its maximum
    bus.stall = 1'b0;
    tick(65535);
    chk("max_fcnt", {16'h0, bus.fetch_count}, 32'hFFFF);
    chk("max_addr", bus.inst_addr, 32'h0003_FFFC);
    chk("max_scnt", {24'h0, bus.stall_count}, 32'hFF);
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'hFFFF_FFFC;
    tick();
    chk("top_addr", bus.inst_addr, 32'hFFFF_FFFC);
    chk("top_fcnt", {16'h0, bus.fetch_count}, 32'hFFFF);
    bus.branch_taken = 1'b0;
    bus.inst_data = 32'h1234_5678;
    tick();
    chk("wrap_addr", bus.inst_addr, 32'h0);
    chk("wrap_fcnt", {16'h0, bus.fetch_count}, 32'h0);
    chk("wrap_pc4", bus.if_id_pc4, 32'h0);
    chk("wrap_instr", bus.if_id_instr, 32'h1234_5678);
    chk("wrap_valid", {31'h0, bus.if_id_valid}, 32'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter PC_INC, default 4, byte increment per sequential fetch.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 Reset  input  1  reset; synchronous, active-high.
REQ-005 stall  input  1  hazard-unit request to freeze PC and IF/ID.
REQ-006 branch_taken  input  1  redirect request from downstream stage.
REQ-007 branch_target  input  32  byte address of redirect.
REQ-008 inst_addr  output  32  address to instruction memory; combinationally equal to PC.
REQ-009 inst_data  input  32  instruction word returned combinationally by instruction memory for inst_addr.
REQ-010 if_id_instr  output  32  registered instruction to decode.
REQ-011 if_id_pc4  output  32  registered PC+PC_INC of that instruction.
REQ-012 if_id_valid  output  1  if_id_instr holds a real fetched instruction.
REQ-013 align_err  output  1  sticky flag: misaligned branch target seen.
REQ-014 fetch_count  output  16  count of instructions loaded into IF/ID.
REQ-015 stall_count  output  8  count of stalled cycles, saturating.

Function
REQ-016 FSM states BOOT, RUN, HOLD; the block SHALL enter BOOT on reset.
REQ-017 BOOT lasts exactly one cycle, loads nothing into IF/ID, then goes to RUN (or HOLD if stall=1 and branch_taken=0).
REQ-018 RUN with stall=0, branch_taken=0: PC<=PC+PC_INC (mod 2^32), if_id_instr<=inst_data, if_id_pc4<=PC+PC_INC, if_id_valid<=1, fetch_count<=fetch_count+1 (wraps at 16'hFFFF->0).
REQ-019 stall=1 and branch_taken=0 (RUN or HOLD): PC, IF/ID and fetch_count hold; state<=HOLD; stall_count increments, saturating at 8'hFF.
REQ-020 HOLD with stall=0, branch_taken=0: behaves as REQ-018 in that cycle and returns to RUN.
REQ-021 branch_taken=1 in any non-reset state, regardless of stall: PC<={branch_target[31:2],2'b00}, if_id_instr<=32'h0, if_id_pc4<=32'h0, if_id_valid<=0, fetch_count unchanged, state<=RUN.
REQ-022 branch_taken=1 with branch_target[1:0]!=2'b00 SHALL set align_err; align_err clears only on reset.
REQ-023 Fetch latency: inst_data sampled at edge N appears on if_id_instr after edge N, one cycle.
REQ-024 inst_addr SHALL always be word-aligned (bits [1:0]=0) when PC_INC is a multiple of 4.
REQ-025 Priority per cycle: Reset > branch_taken > stall > normal advance.

Reset
REQ-026 On Reset=1 at a clock edge: PC<=PC_RESET, if_id_instr<=32'h0, if_id_pc4<=32'h0, if_id_valid<=0, align_err<=0, fetch_count<=0, stall_count<=0, state<=BOOT.
REQ-027 Reset asserted mid-stall or coincident with branch_taken SHALL discard both; reset wins.
REQ-028 While Reset=1, inst_addr SHALL equal PC_RESET from the first edge onward.

Structure
REQ-029 Shared package holds NOP_INSTR (32'h0), PC_RESET default, PC_INC default and the fetch state enum.
REQ-030 PC register and next-PC mux SHALL be a sub-module pc_unit (inputs: clk, Reset, hold, load, load_value; output pc); fetch_stage holds FSM, IF/ID register and counters.

Verification
REQ-031 Reset, then 4 free-run cycles with inst_data=32'hE3A0_1001 -> inst_addr 0,0(BOOT),4,8,12; if_id_pc4 4,8,12; fetch_count=3; if_id_valid=1.
REQ-032 At PC=8 assert stall 3 cycles -> inst_addr stays 8, IF/ID unchanged, stall_count=3, state HOLD; release -> PC=12 next edge.
REQ-033 branch_taken=1, branch_target=32'h40 with stall=1 -> PC=32'h40, if_id_valid=0, if_id_instr=0, align_err=0.
REQ-034 branch_target=32'h43 -> PC=32'h40, align_err=1 and remains 1 through 10 further cycles until Reset.
REQ-035 Hold stall 300 cycles -> stall_count stops at 8'hFF; PC=32'hFFFF_FFFC then advance -> PC=0, fetch_count wraps from 16'hFFFF to 0 when preloaded.
REQ-036 Reset asserted together with branch_taken=1, target 32'h80 -> PC=PC_RESET, state BOOT, all counters 0.
